// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_HIGH = 3'd0,
        ST_IDLE      = 3'd1,
        ST_START     = 3'd2,
        ST_DATA      = 3'd3,
        ST_STOP      = 3'd4
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_BIT    = 8;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = tick ? RELOAD : cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 receiver: pin synchroniser, 16x oversampled deframer and a one-entry
// valid/ready holding register with frame-error and overrun pulses.
//
// state      | meaning
// WAIT_HIGH  | after reset / framing error; wait for an idle-high line
// IDLE       | line idle, looking for a low sample on a tick
// START      | counting to mid start bit to reject glitches
// DATA       | sampling 8 data bits, LSB first, every 16 ticks
// STOP       | sampling stop bit; deliver byte or flag framing error
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_BIT - 1);

    logic       tick;
    logic [1:0] sync_q, sync_d;
    logic       rxd_s;
    state_t     state_q, state_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;
    logic       busy_q, busy_d;
    logic       deliver;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign rxd_s = sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], rxd};
        state_d = state_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        if (tick) begin
            case (state_q)
                ST_WAIT_HIGH: if (rxd_s) state_d = ST_IDLE;
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state_d = ST_START;
                        tcnt_d  = 4'd0;
                    end
                end
                ST_START: begin
                    if (tcnt_q == MID_TICK) begin
                        tcnt_d  = 4'd0;
                        idx_d   = 3'd0;
                        state_d = rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (tcnt_q == LAST_TICK) begin
                        tcnt_d          = 4'd0;
                        shift_d[idx_q]  = rxd_s;
                        if (idx_q == 3'd7) state_d = ST_STOP;
                        else               idx_d   = idx_q + 3'd1;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (tcnt_q == LAST_TICK) begin
                        tcnt_d = 4'd0;
                        if (rxd_s) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
                default: state_d = ST_WAIT_HIGH;
            endcase
        end

        // A consume in the delivery cycle frees the slot for the new byte.
        if (deliver) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= ST_WAIT_HIGH;
            tcnt_q  <= 4'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: serial frames driven at 16*27 clocks per bit,
// received bytes checked against a queue of expected bytes.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int BIT = 432;
    localparam int GAP = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int valid_cycles = 0;
    int hold_drop = 0;
    logic hold_watch = 1'b0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_ferr;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_rx_deframer dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // Inputs change #1 after posedge, so at negedge they show what the next edge takes.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) valid_cycles++;
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (hold_watch && !rx_valid) hold_drop++;
            if (rx_valid && rx_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %02h, none expected", rx_data);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    if (rx_data !== exp_b) begin
                        errors++;
                        $display("FAIL rx_data: got %02h expected %02h", rx_data, exp_b);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int gap);
        rxd = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            hold(BIT);
        end
        rxd = stop_b;
        hold(BIT);
        rxd = 1'b1;
        hold(gap);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        hold(n);
        reset = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int f0, o0, v0;
        logic found;

        vecs[0] = '{data: 8'h55, stop_bit: 1'b1, exp_ferr: 0};
        vecs[1] = '{data: 8'hA3, stop_bit: 1'b1, exp_ferr: 0};
        vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_ferr: 0};
        vecs[3] = '{data: 8'hFF, stop_bit: 1'b1, exp_ferr: 0};
        vecs[4] = '{data: 8'hC3, stop_bit: 1'b0, exp_ferr: 1};

        rxd = 1'b1;
        rx_ready = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;
        apply_reset(5);
        check_outputs_zero("reset");
        hold(GAP);

        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
            if (vecs[i].stop_bit) sb.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_bit, GAP);
            check($sformatf("vec%0d_frame_err", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_valid_cycles", i), 32'(valid_cycles - v0), 32'(vecs[i].stop_bit ? 1 : 0));
            check($sformatf("vec%0d_overrun", i), 32'(ovr_cnt - o0), 32'h0);
            check($sformatf("vec%0d_pending", i), 32'(sb.size()), 32'h0);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
        end

        // Short low glitch: rejected at mid start bit.
        f0 = ferr_cnt; v0 = valid_cycles;
        rxd = 1'b0;
        hold(81);
        rxd = 1'b1;
        hold(69);
        check("glitch_busy_mid", 32'(busy), 32'h1);
        hold(600);
        check("glitch_valid", 32'(valid_cycles - v0), 32'h0);
        check("glitch_frame_err", 32'(ferr_cnt - f0), 32'h0);
        check("glitch_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("glitch_busy", 32'(busy), 32'h0);

        // 0x3C with a low stop bit, line then held low two more bit times.
        f0 = ferr_cnt; v0 = valid_cycles;
        rxd = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = ((8'h3C >> i) & 8'h01) != 0;
            hold(BIT);
        end
        rxd = 1'b0;
        hold(3 * BIT);
        rxd = 1'b1;
        hold(500);
        check("ferr_pulse", 32'(ferr_cnt - f0), 32'h1);
        check("ferr_no_valid", 32'(valid_cycles - v0), 32'h0);
        check("ferr_state", 32'(dut.state_q), 32'(ST_IDLE));
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, GAP);
        check("recover_pending", 32'(sb.size()), 32'h0);

        // Overrun: holding register full with 0x12, 0x34 dropped.
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        sb.push_back(8'h12);
        send_frame(8'h12, 1'b1, GAP);
        check("held_valid", 32'(rx_valid), 32'h1);
        check("held_data", 32'(rx_data), 32'h12);
        hold_watch = 1'b1;
        send_frame(8'h34, 1'b1, GAP);
        hold_watch = 1'b0;
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'h1);
        check("ovr_data_kept", 32'(rx_data), 32'h12);
        check("ovr_valid_drop", 32'(hold_drop), 32'h0);

        // Consume 0x12 exactly in the cycle 0x34 is delivered.
        o0 = ovr_cnt;
        found = 1'b0;
        sb.push_back(8'h34);
        fork
            send_frame(8'h34, 1'b1, GAP);
            begin
                for (int i = 0; i < 6000 && !found; i++) begin
                    @(posedge clk); #1;
                    if (dut.state_q == ST_STOP && dut.tcnt_q == 4'd15 && dut.tick) begin
                        found = 1'b1;
                        rx_ready = 1'b1;
                        @(posedge clk); #1;
                        rx_ready = 1'b0;
                    end
                end
            end
        join
        check("conc_found", 32'(found), 32'h1);
        check("conc_data", 32'(rx_data), 32'h34);
        check("conc_valid", 32'(rx_valid), 32'h1);
        check("conc_overrun", 32'(ovr_cnt - o0), 32'h0);
        rx_ready = 1'b1;
        hold(3);
        check("conc_drained", 32'(rx_valid), 32'h0);
        check("conc_pending", 32'(sb.size()), 32'h0);

        // Reset mid-frame while the line is low, with a byte held.
        rx_ready = 1'b0;
        sb.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, GAP);
        check("pre_reset_valid", 32'(rx_valid), 32'h1);
        rxd = 1'b0;
        hold(4 * BIT + BIT / 2);
        apply_reset(2);
        sb.delete();
        check_outputs_zero("midframe_reset");
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = valid_cycles;
        hold(BIT / 2 - 3);
        rxd = 1'b1;
        hold(5 * BIT + GAP);
        check("post_reset_valid", 32'(valid_cycles - v0), 32'h0);
        check("post_reset_ferr", 32'(ferr_cnt - f0), 32'h0);
        check("post_reset_ovr", 32'(ovr_cnt - o0), 32'h0);
        rx_ready = 1'b1;
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, GAP);
        check("after_reset_data", 32'(rx_data), 32'h0F);
        check("after_reset_pending", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
